// File: rtl/matrix_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_operand_loader
//  Description : Double-buffered operand feeder for the 3x3 matrix multiplier.
//                Collects an 18-byte stream (A row-major, then B row-major)
//                into a shadow bank. When the shadow bank is full and the
//                engine is idle, it copies the bank to the active operand
//                registers and runs the multiplier start/done handshake.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                in_valid/in_ready - element stream handshake, in_data byte
//                abort             - drop the partially loaded shadow frame
//                a_flat/b_flat     - active operands, a11 at [7:0]
//                mm_start/mm_done  - multiplier handshake
//                result_valid      - one-cycle pulse, multiplier output valid
//                busy              - engine not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_operand_loader #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                abort,
    output logic [9*DATA_W-1:0] a_flat,
    output logic [9*DATA_W-1:0] b_flat,
    output logic                mm_start,
    input  logic                mm_done,
    output logic                result_valid,
    output logic                busy
);

    localparam int         c_NUM_ELEM = 18;
    localparam logic [4:0] c_LAST_IDX = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Shadow (load-side) bank
    logic [4:0]                   r_count;
    logic                         r_shadow_full;
    logic [c_NUM_ELEM*DATA_W-1:0] r_shadow;

    // Engine and active bank
    state_t                       r_state;
    state_t                       w_state_next;
    logic                         r_mm_start;
    logic                         w_mm_start_next;
    logic                         r_result_valid;
    logic                         w_result_valid_next;
    logic                         w_transfer;
    logic [9*DATA_W-1:0]          r_a_active;
    logic [9*DATA_W-1:0]          r_b_active;

    logic                         w_accept;

    // Reset gates in_ready combinationally so nothing is taken while held.
    assign in_ready = !r_shadow_full && !rst;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Load side: element counter and full flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_shadow_full <= 1'b0;
        end else if (abort) begin
            // Abort wins over an element offered in the same cycle.
            r_count       <= '0;
            r_shadow_full <= 1'b0;
        end else if (w_transfer) begin
            r_shadow_full <= 1'b0;
        end else if (w_accept) begin
            if (r_count == c_LAST_IDX) begin
                r_count       <= '0;
                r_shadow_full <= 1'b1;
            end else begin
                r_count <= r_count + 5'd1;
            end
        end
    end

    // Shadow storage: slot k receives the k-th accepted element.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_accept && !abort) begin
            for (int k = 0; k < c_NUM_ELEM; k++) begin
                if (r_count == 5'(k)) begin
                    r_shadow[k*DATA_W +: DATA_W] <= in_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Engine FSM: next state and next registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        w_mm_start_next     = 1'b0;
        w_result_valid_next = 1'b0;
        w_transfer          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_shadow_full) begin
                    w_transfer      = 1'b1;
                    w_mm_start_next = 1'b1;
                    w_state_next    = S_RUN;
                end
            end
            S_RUN: begin
                if (mm_done) begin
                    w_result_valid_next = 1'b1;
                    w_state_next        = S_RELEASE;
                end else begin
                    w_mm_start_next = 1'b1;
                end
            end
            S_RELEASE: begin
                // Wait for done to drop so a lingering done cannot
                // complete the next frame immediately.
                if (!mm_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_mm_start     <= 1'b0;
            r_result_valid <= 1'b0;
            r_a_active     <= '0;
            r_b_active     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_mm_start     <= w_mm_start_next;
            r_result_valid <= w_result_valid_next;
            if (w_transfer) begin
                r_a_active <= r_shadow[9*DATA_W-1:0];
                r_b_active <= r_shadow[18*DATA_W-1:9*DATA_W];
            end
        end
    end

    assign a_flat       = r_a_active;
    assign b_flat       = r_b_active;
    assign mm_start     = r_mm_start;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
Upstream feeder for the 3x3 multiplier (matrix_mult_top). It accepts an 18-element byte stream over a valid/ready handshake, ordered as A row-major then B row-major, into a shadow bank. When the shadow bank is full and the multiplier is free, it transfers the bank to an active bank that drives the multiplier operands, then runs the multiplier's start/done handshake. Double buffering lets the next frame load while the current product is computed.

Parameters:
DATA_W, 8, element width; fixed at 8 to match the multiplier inputs.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  stream element valid
in_ready  out  1  loader can accept an element
in_data  in  DATA_W  stream element
abort  in  1  synchronous clear of the partially loaded shadow frame
a_flat  out  9*DATA_W  active A; element a(r+1)(c+1) at [DATA_W*(3r+c) +: DATA_W], so a11 is at [7:0]
b_flat  out  9*DATA_W  active B; same mapping
mm_start  out  1  to multiplier start
mm_done  in  1  from multiplier done
result_valid  out  1  one-cycle pulse: multiplier results valid this cycle
busy  out  1  engine FSM not in IDLE

Behaviour:
- Reset values (synchronous):
  - a_flat=0, b_flat=0, mm_start=0, result_valid=0, busy=0.
  - Shadow count=0, shadow_full=0, FSM=IDLE.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst is released.
- Load side:
  - in_ready = !shadow_full && !rst.
  - An element is accepted when in_valid && in_ready at the clock edge.
  - Element k (0..17) is written to shadow slot k: slots 0-8 are A row-major, slots 9-17 are B row-major.
  - Count increments per accepted element and holds when in_valid is low.
  - The accept of element 17 sets shadow_full and resets count to 0.
- abort:
  - Clears count to 0 and shadow_full to 0.
  - Discards any shadow contents.
  - Never touches the active bank or the engine FSM.
  - Takes priority over an element accepted in the same cycle; that element is dropped.
- Engine FSM:
  - IDLE: if shadow_full, then copy shadow to a_flat/b_flat, clear shadow_full, set mm_start=1, go to RUN.
  - RUN: mm_start stays 1 and a_flat/b_flat are held stable. When mm_done=1 is sampled: mm_start=0, result_valid=1 for exactly one cycle (the cycle after the edge sampling done), go to RELEASE.
  - RELEASE: mm_start=0. Go to IDLE on the first cycle mm_done is sampled 0. This guards against a stale done starting the next frame.
  - busy=1 in RUN and RELEASE.
- Latency:
  - Last element accepted on edge E → shadow_full after E.
  - If the FSM is in IDLE, mm_start=1 and a_flat/b_flat are updated after E+1.
  - in_ready returns to 1 after E+1.
- Simultaneous events:
  - No element can be accepted on the transfer cycle, because in_ready=0 while shadow_full.
  - The next frame may load fully during RUN/RELEASE. It then stalls with in_ready=0 until IDLE performs the transfer.
  - Back-to-back frames give mm_start low for at least one cycle (the RELEASE cycle(s) plus the IDLE cycle) between products.
- Reset mid-operation: all state returns to reset values on the next edge. mm_start drops immediately; the shadow frame is lost.
- abort during RUN leaves mm_start, a_flat and b_flat unaffected.
- Active operands change only on a transfer, so they are constant for the whole start→done window.

Test Plan:
1. Basic frame: stream 1,2,...,9 then 9,8,...,1 with in_valid held high; bench multiplier asserts done 5 cycles after start and holds it 2 cycles → a_flat=0x090807060504030201, b_flat=0x010203040506070809; mm_start high 1 cycle after the 18th accept; result_valid single pulse; back to IDLE after done falls.
2. Backpressure gaps: same data with in_valid toggling 1,0,0,1,... → identical a_flat/b_flat; count holds during gaps; exactly 18 accepts.
3. Double buffering: send frame 2 (all A=2, all B=3) during frame 1's RUN → in_ready=0 after the 18th frame-2 accept; a_flat unchanged until RELEASE→IDLE; second mm_start preceded by ≥1 low cycle; a_flat=0x020202020202020202.
4. Stale done: hold mm_done high 10 cycles after the first done, with frame 2 buffered → FSM stays in RELEASE, no second mm_start until done falls.
5. Abort: accept 7 elements, pulse abort together with in_valid on element 8, then send a full fresh frame of 5s → element 8 not stored; active A and B are all 5s.
6. Reset mid-RUN: assert rst for 1 cycle while mm_start=1 → next cycle mm_start=0, a_flat=0, busy=0, in_ready=1 after release.
